prng_lfsr_engine: RTL and testbench



---
 rtl/prng_pkg.sv | 24 ++
 rtl/prng_ctrl_fsm.sv | 87 ++++++++
 rtl/prng_lfsr_engine.sv | 126 ++++++++++++
 tb/tb_prng_lfsr_engine.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared types and helpers for the PRNG LFSR engine.
// State encoding, default feedback taps and beat-counter sizing.
package prng_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SHIFT    = 2'b01,
    DATAOUT  = 2'b10,
    SEEDLOAD = 2'b11
  } state_t;

  // x^32 + x^22 + x^2 + x + 1 in Galois (right-shift) form
  localparam logic [31:0] DEFAULT_TAPS_32 = 32'h8020_0003;

  // Ceil-log2 of a beat count, never less than one bit so a single-beat
  // configuration still gets a legal counter.
  function automatic int beat_cnt_w(input int beats);
    int w;
    w = 1;
    while ((1 << w) < beats) w++;
    return w;
  endfunction

endpackage

// File: rtl/prng_ctrl_fsm.sv
// Control FSM for the PRNG engine: state register, request arbitration
// and the output / seed beat counters that generate completion.
module prng_ctrl_fsm
  import prng_pkg::*;
#(
  parameter int OUT_BEATS  = 4,
  parameter int SEED_BEATS = 4,
  parameter int OBW        = beat_cnt_w(OUT_BEATS),
  parameter int SBW        = beat_cnt_w(SEED_BEATS)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           get_random,
  input  logic           load_seed,
  input  logic           rnd_ready,
  input  logic           seed_valid,
  output state_t         state,
  output logic           busy,
  output logic [OBW-1:0] out_beat,
  output logic [SBW-1:0] seed_beat,
  output logic           out_last,
  output logic           seed_last,
  output logic           seed_start
);

  // Current beat is the final slice of the word / seed being moved.
  assign out_last   = (state == DATAOUT)  && (out_beat  == OBW'(OUT_BEATS - 1));
  assign seed_last  = (state == SEEDLOAD) && (seed_beat == SBW'(SEED_BEATS - 1));

  // Entry into SEEDLOAD this cycle; get_random wins over load_seed.
  assign seed_start = ((state == IDLE) || (state == SHIFT)) && !get_random && load_seed;

  // State, busy flag and both beat counters; requests are only looked at in
  // IDLE/SHIFT so anything arriving during a transfer is simply dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_beat  <= '0;
      seed_beat <= '0;
    end else begin
      case (state)
        IDLE, SHIFT: begin
          if (get_random) begin
            state    <= DATAOUT;
            busy     <= 1'b1;
            out_beat <= '0;
          end else if (load_seed) begin
            state     <= SEEDLOAD;
            busy      <= 1'b1;
            seed_beat <= '0;
          end else begin
            state <= SHIFT;
            busy  <= 1'b0;
          end
        end
        DATAOUT: begin
          if (rnd_ready) begin
            if (out_last) begin
              out_beat <= '0;
              state    <= SHIFT;
              busy     <= 1'b0;
            end else begin
              out_beat <= out_beat + 1'b1;
            end
          end
        end
        SEEDLOAD: begin
          if (seed_valid) begin
            if (seed_last) begin
              seed_beat <= '0;
              state     <= SHIFT;
              busy      <= 1'b0;
            end else begin
              seed_beat <= seed_beat + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/prng_lfsr_engine.sv
// PRNG engine: Galois LFSR datapath, multi-beat seed assembly and the
// beat-sliced valid/ready output stream.
// Optional feature macro PRNG_WORD_CNT_EN adds a 32-bit delivered-word counter.
module prng_lfsr_engine
  import prng_pkg::*;
#(
  parameter int                LFSR_W    = 32,
  parameter int                OUT_W     = 8,
  parameter int                SEED_W    = 8,
  parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(DEFAULT_TAPS_32),
  parameter logic [LFSR_W-1:0] INIT_SEED = LFSR_W'(1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              get_random,
  input  logic              load_seed,
  input  logic [SEED_W-1:0] seed_data,
  input  logic              seed_valid,
  output logic              seed_ready,
  output logic [OUT_W-1:0]  rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic [1:0]        state,
  output logic              busy
`ifdef PRNG_WORD_CNT_EN
  ,
  output logic [31:0]       word_cnt
`endif
);

  localparam int OUT_BEATS  = LFSR_W / OUT_W;
  localparam int SEED_BEATS = LFSR_W / SEED_W;
  localparam int OBW        = beat_cnt_w(OUT_BEATS);
  localparam int SBW        = beat_cnt_w(SEED_BEATS);

  state_t             st;
  logic [OBW-1:0]     out_beat;
  logic [SBW-1:0]     seed_beat;
  logic               out_last;
  logic               seed_last;
  logic               seed_start;
  logic               rnd_fire;
  logic               seed_fire;
  logic [LFSR_W-1:0]  lfsr;
  logic [LFSR_W-1:0]  lfsr_next;
  logic [LFSR_W-1:0]  seed_acc;
  logic [LFSR_W-1:0]  seed_word;

  prng_ctrl_fsm #(
    .OUT_BEATS  (OUT_BEATS),
    .SEED_BEATS (SEED_BEATS),
    .OBW        (OBW),
    .SBW        (SBW)
  ) u_ctrl (
    .clk        (clk),
    .rstn       (rstn),
    .get_random (get_random),
    .load_seed  (load_seed),
    .rnd_ready  (rnd_ready),
    .seed_valid (seed_valid),
    .state      (st),
    .busy       (busy),
    .out_beat   (out_beat),
    .seed_beat  (seed_beat),
    .out_last   (out_last),
    .seed_last  (seed_last),
    .seed_start (seed_start)
  );

  assign state      = st;
  assign rnd_valid  = (st == DATAOUT);
  assign seed_ready = (st == SEEDLOAD);
  assign rnd_fire   = rnd_valid && rnd_ready;
  assign seed_fire  = seed_valid && seed_ready;

  // Output slice follows the beat counter; forced to zero when not valid.
  assign rnd_data = rnd_valid ? lfsr[out_beat*OUT_W +: OUT_W] : '0;

  // Assemble the seed word with the incoming beat merged in, so the final
  // beat can load the LFSR in the same cycle it is accepted.
  always_comb begin
    seed_word = seed_acc;
    seed_word[seed_beat*SEED_W +: SEED_W] = seed_data;
    lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
  end

  // Seed accumulator: cleared on SEEDLOAD entry, filled one slice per beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seed_acc <= '0;
    end else if (seed_start) begin
      seed_acc <= '0;
    end else if (seed_fire) begin
      seed_acc[seed_beat*SEED_W +: SEED_W] <= seed_data;
    end
  end

  // LFSR free-runs in SHIFT and is replaced by a completed seed, with an
  // all-zero seed mapped to 1 so the register can never lock up.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr <= INIT_SEED;
    end else if (st == SHIFT) begin
      lfsr <= lfsr_next;
    end else if (seed_fire && seed_last) begin
      lfsr <= (seed_word == '0) ? LFSR_W'(1) : seed_word;
    end
  end

`ifdef PRNG_WORD_CNT_EN
  // Count fully delivered words; a completed seed load restarts the count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_cnt <= '0;
    end else if (seed_fire && seed_last) begin
      word_cnt <= '0;
    end else if (rnd_fire && out_last) begin
      word_cnt <= word_cnt + 32'd1;
    end
  end
`else
  logic unused_fire;
  assign unused_fire = rnd_fire;
`endif

endmodule

// File: tb/tb_prng_lfsr_engine.sv
// Directed self-checking bench for prng_lfsr_engine (default 32/8/8 build).
// Exercises reset, seed load, backpressure, zero seed, request priority and
// reset during a seed load; word counter checks run when PRNG_WORD_CNT_EN is set.
module tb_prng_lfsr_engine;

  logic        clk;
  logic        rstn;
  logic        get_random;
  logic        load_seed;
  logic [7:0]  seed_data;
  logic        seed_valid;
  logic        seed_ready;
  logic [7:0]  rnd_data;
  logic        rnd_valid;
  logic        rnd_ready;
  logic [1:0]  state;
  logic        busy;
`ifdef PRNG_WORD_CNT_EN
  logic [31:0] word_cnt;
`endif

  int checks;
  int failures;

  prng_lfsr_engine dut (
    .clk        (clk),
    .rstn       (rstn),
    .get_random (get_random),
    .load_seed  (load_seed),
    .seed_data  (seed_data),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .rnd_data   (rnd_data),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .state      (state),
    .busy       (busy)
`ifdef PRNG_WORD_CNT_EN
    ,
    .word_cnt   (word_cnt)
`endif
  );

  // Free-running clock, rising edge active.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Enter SEEDLOAD from SHIFT and stream four bytes, LSB first.
  task automatic do_seed(input logic [31:0] w);
    load_seed = 1'b1;
    step();
    load_seed = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seed_valid = 1'b1;
      seed_data  = w[i*8 +: 8];
      step();
    end
    seed_valid = 1'b0;
    seed_data  = 8'h00;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) step();
    checks++; if (state !== 2'b00) begin failures++; $display("[TB] FAIL reset_state got=%b exp=00", state); end
    checks++; if (rnd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rnd_valid got=%b exp=0", rnd_valid); end
    checks++; if (seed_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_seed_ready got=%b exp=0", seed_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rnd_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_rnd_data got=%h exp=00", rnd_data); end
    checks++; if (dut.lfsr !== 32'h0000_0001) begin failures++; $display("[TB] FAIL reset_lfsr got=%h exp=00000001", dut.lfsr); end
    rstn = 1'b1;
    step();
    checks++; if (state !== 2'b01) begin failures++; $display("[TB] FAIL post_reset_state got=%b exp=01", state); end
    checks++; if (dut.lfsr !== 32'h0000_0001) begin failures++; $display("[TB] FAIL idle_hold_lfsr got=%h exp=00000001", dut.lfsr); end
    step();
    checks++; if (dut.lfsr !== 32'h8020_0003) begin failures++; $display("[TB] FAIL first_step_lfsr got=%h exp=80200003", dut.lfsr); end
    checks++; if (rnd_data !== 8'h00) begin failures++; $display("[TB] FAIL shift_rnd_data got=%h exp=00", rnd_data); end
  endtask

  task automatic test_seed_load();
    logic [31:0] w;
    w = 32'h0000_0001;
    load_seed = 1'b1;
    step();
    load_seed = 1'b0;
    checks++; if (state !== 2'b11) begin failures++; $display("[TB] FAIL seed_state got=%b exp=11", state); end
    checks++; if (seed_ready !== 1'b1) begin failures++; $display("[TB] FAIL seed_ready got=%b exp=1", seed_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL seed_busy got=%b exp=1", busy); end
    for (int i = 0; i < 4; i++) begin
      seed_valid = 1'b1;
      seed_data  = w[i*8 +: 8];
      step();
    end
    seed_valid = 1'b0;
    checks++; if (state !== 2'b01) begin failures++; $display("[TB] FAIL seed_done_state got=%b exp=01", state); end
    checks++; if (dut.lfsr !== 32'h0000_0001) begin failures++; $display("[TB] FAIL seed_lfsr got=%h exp=00000001", dut.lfsr); end
    get_random = 1'b1;
    rnd_ready  = 1'b1;
    step();
    get_random = 1'b0;
    w = 32'h8020_0003;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rnd_valid !== 1'b1) begin failures++; $display("[TB] FAIL word_valid beat=%0d got=%b exp=1", i, rnd_valid); end
      checks++; if (rnd_data !== w[i*8 +: 8]) begin failures++; $display("[TB] FAIL word_beat beat=%0d got=%h exp=%h", i, rnd_data, w[i*8 +: 8]); end
      step();
    end
    checks++; if (state !== 2'b01) begin failures++; $display("[TB] FAIL word_done_state got=%b exp=01", state); end
    checks++; if (rnd_valid !== 1'b0) begin failures++; $display("[TB] FAIL word_done_valid got=%b exp=0", rnd_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    do_seed(32'h0000_0001);
    w = 32'h8020_0003;
    rnd_ready  = 1'b1;
    get_random = 1'b1;
    step();
    get_random = 1'b0;
    checks++; if (rnd_data !== w[7:0]) begin failures++; $display("[TB] FAIL bp_beat0 got=%h exp=%h", rnd_data, w[7:0]); end
    step();
    rnd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rnd_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_stall_valid cyc=%0d got=%b exp=1", i, rnd_valid); end
      checks++; if (rnd_data !== w[15:8]) begin failures++; $display("[TB] FAIL bp_stall_data cyc=%0d got=%h exp=%h", i, rnd_data, w[15:8]); end
      checks++; if (state !== 2'b10) begin failures++; $display("[TB] FAIL bp_stall_state cyc=%0d got=%b exp=10", i, state); end
      step();
    end
    rnd_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      checks++; if (rnd_data !== w[i*8 +: 8]) begin failures++; $display("[TB] FAIL bp_resume beat=%0d got=%h exp=%h", i, rnd_data, w[i*8 +: 8]); end
      step();
    end
    checks++; if (state !== 2'b01) begin failures++; $display("[TB] FAIL bp_done_state got=%b exp=01", state); end
  endtask

  task automatic test_zero_seed();
    do_seed(32'h0000_0000);
    checks++; if (dut.lfsr !== 32'h0000_0001) begin failures++; $display("[TB] FAIL zero_seed_lfsr got=%h exp=00000001", dut.lfsr); end
    checks++; if (state !== 2'b01) begin failures++; $display("[TB] FAIL zero_seed_state got=%b exp=01", state); end
    step();
    checks++; if (dut.lfsr !== 32'h8020_0003) begin failures++; $display("[TB] FAIL zero_seed_step got=%h exp=80200003", dut.lfsr); end
  endtask

  task automatic test_priority();
    logic [31:0] w;
    // lfsr is 80200003 here and steps once more on the request edge
    w = 32'hC030_0002;
    rnd_ready  = 1'b1;
    get_random = 1'b1;
    load_seed  = 1'b1;
    step();
    get_random = 1'b0;
    checks++; if (state !== 2'b10) begin failures++; $display("[TB] FAIL prio_state got=%b exp=10", state); end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) load_seed = 1'b0;
      checks++; if (seed_ready !== 1'b0) begin failures++; $display("[TB] FAIL prio_seed_ready beat=%0d got=%b exp=0", i, seed_ready); end
      checks++; if (rnd_data !== w[i*8 +: 8]) begin failures++; $display("[TB] FAIL prio_beat beat=%0d got=%h exp=%h", i, rnd_data, w[i*8 +: 8]); end
      step();
    end
    checks++; if (state !== 2'b01) begin failures++; $display("[TB] FAIL prio_done_state got=%b exp=01", state); end
    step();
    checks++; if (state !== 2'b01) begin failures++; $display("[TB] FAIL prio_no_queue got=%b exp=01", state); end
    checks++; if (seed_ready !== 1'b0) begin failures++; $display("[TB] FAIL prio_no_queue_ready got=%b exp=0", seed_ready); end
  endtask

  task automatic test_reset_mid_seed();
    logic [31:0] w;
    load_seed = 1'b1;
    step();
    load_seed  = 1'b0;
    seed_valid = 1'b1;
    seed_data  = 8'hAA;
    step();
    seed_data  = 8'hBB;
    step();
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (state !== 2'b00) begin failures++; $display("[TB] FAIL midrst_state got=%b exp=00", state); end
    checks++; if (dut.lfsr !== 32'h0000_0001) begin failures++; $display("[TB] FAIL midrst_lfsr got=%h exp=00000001", dut.lfsr); end
    checks++; if (seed_ready !== 1'b0) begin failures++; $display("[TB] FAIL midrst_seed_ready got=%b exp=0", seed_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy got=%b exp=0", busy); end
    seed_valid = 1'b0;
    step();
    rstn = 1'b1;
    step();
    checks++; if (state !== 2'b01) begin failures++; $display("[TB] FAIL midrst_release got=%b exp=01", state); end
    do_seed(32'h1234_5678);
    checks++; if (dut.lfsr !== 32'h1234_5678) begin failures++; $display("[TB] FAIL fresh_seed_lfsr got=%h exp=12345678", dut.lfsr); end
    w = 32'h091A_2B3C;
    rnd_ready  = 1'b1;
    get_random = 1'b1;
    step();
    get_random = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rnd_data !== w[i*8 +: 8]) begin failures++; $display("[TB] FAIL fresh_word beat=%0d got=%h exp=%h", i, rnd_data, w[i*8 +: 8]); end
      step();
    end
  endtask

`ifdef PRNG_WORD_CNT_EN
  task automatic test_word_cnt();
    checks++; if (word_cnt !== 32'd1) begin failures++; $display("[TB] FAIL word_cnt_one got=%0d exp=1", word_cnt); end
    rnd_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      get_random = 1'b1;
      step();
      get_random = 1'b0;
      repeat (4) step();
    end
    checks++; if (word_cnt !== 32'd3) begin failures++; $display("[TB] FAIL word_cnt_three got=%0d exp=3", word_cnt); end
    do_seed(32'h0000_0005);
    checks++; if (word_cnt !== 32'd0) begin failures++; $display("[TB] FAIL word_cnt_clear got=%0d exp=0", word_cnt); end
  endtask
`endif

  initial begin
    checks     = 0;
    failures   = 0;
    rstn       = 1'b0;
    get_random = 1'b0;
    load_seed  = 1'b0;
    seed_data  = 8'h00;
    seed_valid = 1'b0;
    rnd_ready  = 1'b0;
    test_reset();
    test_seed_load();
    test_backpressure();
    test_zero_seed();
    test_priority();
    test_reset_mid_seed();
`ifdef PRNG_WORD_CNT_EN
    test_word_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
